// File: rtl/mio_pkg.sv
// Shared constants and index helpers for the MIO receive-side arbiter and
// any other rotating-priority scheduler built on mrx_arb_rr.
package mio_pkg;

   localparam int MRX_ARB_NMAX = 8;
   localparam int MRX_ARB_IDW  = 3;

   // Encodes a one-hot (or all-zero) vector into its bit index; all-zero gives 0.
   function automatic logic [MRX_ARB_IDW-1:0] onehot_to_idx(
      input logic [MRX_ARB_NMAX-1:0] oh
   );
      logic [MRX_ARB_IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < MRX_ARB_NMAX; i++) begin
         if (oh[i]) idx = idx | MRX_ARB_IDW'(i);
      end
      return idx;
   endfunction

   function automatic logic [MRX_ARB_IDW-1:0] next_idx(
      input logic [MRX_ARB_IDW-1:0] idx,
      input int                     n
   );
      if (int'(idx) + 1 >= n) return '0;
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/mrx_arb_rr.sv
// Combinational rotating-priority picker: the first set bit of req at or
// after ptr (with wrap) wins; gnt is one-hot, or zero when req is zero.
module mrx_arb_rr
   import mio_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]           req,
   input  logic [MRX_ARB_IDW-1:0] ptr,
   output logic [N-1:0]           gnt,
   output logic [MRX_ARB_IDW-1:0] win
);

   logic [N-1:0] rot;
   logic [N-1:0] gnt_rot;

   // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      rot     = N'({req, req} >> ptr);
      gnt_rot = rot & (~rot + N'(1));
      gnt     = N'(({gnt_rot, gnt_rot} << ptr) >> N);
      win     = onehot_to_idx(MRX_ARB_NMAX'(gnt));
   end

endmodule

// File: rtl/mrx_arbiter.sv
// Round-robin arbiter merging N receive FIFOs onto one emesh port through a
// one-deep output register. Optional grant lock: define MRX_ARB_LOCK_EN.
module mrx_arbiter
   import mio_pkg::*;
#(
   parameter int N        = 4,
   parameter int PW       = 104,
   parameter int LOCK_MAX = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           en,
   input  logic [N-1:0]           access_in,
   input  logic [N*PW-1:0]        packet_in,
   output logic [N-1:0]           wait_out,
   output logic                   access_out,
   output logic [PW-1:0]          packet_out,
   output logic [MRX_ARB_IDW-1:0] grant_id,
   input  logic                   wait_in
);

   if (N < 2 || N > MRX_ARB_NMAX) begin : g_bad_n
      $error("mrx_arbiter: N out of range");
   end
   if (LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_bad_lock
      $error("mrx_arbiter: LOCK_MAX out of range");
   end

   // Handshake on both sides: a transfer happens on a clk edge where access is
   // high and the matching wait is low; while wait is high the sender holds
   // access and packet unchanged.

   logic                   ld;
   logic [N-1:0]           req;
   logic [N-1:0]           rr_gnt;
   logic [MRX_ARB_IDW-1:0] rr_win;
   logic [MRX_ARB_IDW-1:0] rr_ptr;
   logic [N-1:0]           gnt;
   logic [MRX_ARB_IDW-1:0] win;
   logic [MRX_ARB_IDW-1:0] ptr;
   logic [PW-1:0]          sel_pkt;

   assign ld  = ~access_out | ~wait_in;
   assign req = access_in & en;

   mrx_arb_rr #(.N(N)) u_rr (
      .req (req),
      .ptr (rr_ptr),
      .gnt (rr_gnt),
      .win (rr_win)
   );

`ifdef MRX_ARB_LOCK_EN
   logic [3:0]   lock_cnt;
   logic [3:0]   lock_cnt_nxt;
   logic [N-1:0] last_oh;
   logic         lock_hold;

   // While a lock is open, ptr is stale; the search restarts after the holder.
   assign last_oh      = N'(1) << grant_id;
   assign lock_hold    = (lock_cnt != 4'd0) && ((req & last_oh) != '0);
   assign rr_ptr       = (lock_cnt != 4'd0) ? next_idx(grant_id, N) : ptr;
   assign gnt          = lock_hold ? last_oh : rr_gnt;
   assign win          = lock_hold ? grant_id : rr_win;
   assign lock_cnt_nxt = lock_hold ? lock_cnt + 4'd1 : 4'd1;
`else
   assign rr_ptr = ptr;
   assign gnt    = rr_gnt;
   assign win    = rr_win;
`endif

   always_comb begin
      sel_pkt = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) sel_pkt = packet_in[i*PW +: PW];
      end
   end

   // No grant is issued while reset is high, so every requester sees wait.
   assign wait_out = ~({N{ld & ~reset}} & gnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         access_out <= 1'b0;
         packet_out <= '0;
         grant_id   <= '0;
         ptr        <= '0;
`ifdef MRX_ARB_LOCK_EN
         lock_cnt   <= 4'd0;
`endif
      end else if (ld) begin
         if (req != '0) begin
            access_out <= 1'b1;
            packet_out <= sel_pkt;
            grant_id   <= win;
`ifdef MRX_ARB_LOCK_EN
            if (int'(lock_cnt_nxt) >= LOCK_MAX) begin
               ptr      <= next_idx(win, N);
               lock_cnt <= 4'd0;
            end else begin
               lock_cnt <= lock_cnt_nxt;
            end
`else
            ptr        <= next_idx(win, N);
`endif
         end else begin
            access_out <= 1'b0;
`ifdef MRX_ARB_LOCK_EN
            if (lock_cnt != 4'd0) begin
               ptr      <= next_idx(grant_id, N);
               lock_cnt <= 4'd0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_mrx_arbiter.sv
// Self-checking bench for mrx_arbiter (N=4, PW=104, LOCK_MAX=3); expected
// lock sequence follows MRX_ARB_LOCK_EN.
module tb_mrx_arbiter;

   localparam int N        = 4;
   localparam int PW       = 104;
   localparam int LOCK_MAX = 3;
   localparam int W        = 3 + PW;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    en;
   logic [N-1:0]    access_in;
   logic [N*PW-1:0] packet_in;
   logic [N-1:0]    wait_out;
   logic            access_out;
   logic [PW-1:0]   packet_out;
   logic [2:0]      grant_id;
   logic            wait_in;

   logic [PW-1:0]   pkt [N];
   logic [W-1:0]    exp_q [$];
   int              n_vec = 0;
   int              n_err = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) packet_in[i*PW +: PW] = pkt[i];
   end

   mrx_arbiter #(.N(N), .PW(PW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .access_in  (access_in),
      .packet_in  (packet_in),
      .wait_out   (wait_out),
      .access_out (access_out),
      .packet_out (packet_out),
      .grant_id   (grant_id),
      .wait_in    (wait_in)
   );

   // ---------------- driver tasks ----------------
   task automatic new_pkts();
      for (int i = 0; i < N; i++)
         pkt[i] = {8'(i), 32'($urandom()), 32'($urandom()), 32'($urandom())};
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic r, input logic [N-1:0] a, input logic [N-1:0] e,
                        input logic w);
      @(negedge clk);
      reset = r; access_in = a; en = e; wait_in = w;
      new_pkts();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 4'b1111, 4'b1111, 1'b0);
         n_vec++;
         if (wait_out !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_wait[%0d]: got %b want 1111", c, wait_out);
         end
         @(posedge clk); #1;
         n_vec++;
         if (access_out !== 1'b0 || packet_out !== '0 || grant_id !== 3'd0) begin
            n_err++;
            $display("FAIL reset_out[%0d]: got access=%b id=%0d pkt=%h want 0/0/0",
                     c, access_out, grant_id, packet_out);
         end
      end
   endtask

   task automatic test_rotation();
      int           gs [6] = '{0, 1, 2, 3, 0, 1};
      logic [N-1:0] oh;
      logic [W-1:0] exp_v;
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 4'b1111, 4'b1111, 1'b0);
         oh = N'(1) << gs[c];
         exp_q.push_back({3'(gs[c]), pkt[gs[c]]});
         n_vec++;
         if (wait_out !== ~oh) begin
            n_err++;
            $display("FAIL rotation_wait[%0d]: got %b want %b", c, wait_out, ~oh);
         end
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         n_vec++;
         if (access_out !== 1'b1 || {grant_id, packet_out} !== exp_v) begin
            n_err++;
            $display("FAIL rotation[%0d]: got access=%b id=%0d pkt=%h want id=%0d pkt=%h",
                     c, access_out, grant_id, packet_out, exp_v[W-1 -: 3], exp_v[PW-1:0]);
         end
      end
   endtask

   task automatic test_stall();
      logic [W-1:0] exp_v;
      drive(1'b0, 4'b0100, 4'b1111, 1'b0);
      pkt[2] = 104'hA5; #1;
      exp_q.push_back({3'd2, 104'hA5});
      n_vec++;
      if (wait_out !== 4'b1011) begin
         n_err++;
         $display("FAIL stall_load_wait: got %b want 1011", wait_out);
      end
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (access_out !== 1'b1 || {grant_id, packet_out} !== exp_v) begin
         n_err++;
         $display("FAIL stall_load: got access=%b id=%0d pkt=%h want id=2 pkt=a5",
                  access_out, grant_id, packet_out);
      end
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 4'b0100, 4'b1111, 1'b1);
         pkt[2] = 104'h5A; #1;
         if (c == 0) exp_q.push_back({3'd2, 104'h5A});
         n_vec++;
         if (wait_out !== 4'b1111) begin
            n_err++;
            $display("FAIL stall_wait[%0d]: got %b want 1111", c, wait_out);
         end
         @(posedge clk); #1;
         n_vec++;
         if (access_out !== 1'b1 || grant_id !== 3'd2 || packet_out !== 104'hA5) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got access=%b id=%0d pkt=%h want 1/2/a5",
                     c, access_out, grant_id, packet_out);
         end
      end
      drive(1'b0, 4'b0100, 4'b1111, 1'b0);
      pkt[2] = 104'h5A; #1;
      n_vec++;
      if (wait_out !== 4'b1011) begin
         n_err++;
         $display("FAIL stall_release_wait: got %b want 1011", wait_out);
      end
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (access_out !== 1'b1 || {grant_id, packet_out} !== exp_v) begin
         n_err++;
         $display("FAIL stall_release: got access=%b id=%0d pkt=%h want id=2 pkt=5a",
                  access_out, grant_id, packet_out);
      end
      // Idle cycle: valid drops, id and packet hold.
      drive(1'b0, 4'b0000, 4'b1111, 1'b0);
      n_vec++;
      if (wait_out !== 4'b1111) begin
         n_err++;
         $display("FAIL idle_wait: got %b want 1111", wait_out);
      end
      @(posedge clk); #1;
      n_vec++;
      if (access_out !== 1'b0 || grant_id !== 3'd2 || packet_out !== 104'h5A) begin
         n_err++;
         $display("FAIL idle_hold: got access=%b id=%0d pkt=%h want 0/2/5a",
                  access_out, grant_id, packet_out);
      end
   endtask

   task automatic test_enable();
      int           gs [4] = '{1, 3, 1, 3};
      logic [N-1:0] oh;
      logic [W-1:0] exp_v;
      // Reset pulse brings ptr back to 0.
      drive(1'b1, 4'b1111, 4'b1010, 1'b0);
      @(posedge clk); #1;
      n_vec++;
      if (access_out !== 1'b0) begin
         n_err++;
         $display("FAIL enable_reset: got access=%b want 0", access_out);
      end
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 4'b1111, 4'b1010, 1'b0);
         oh = N'(1) << gs[c];
         exp_q.push_back({3'(gs[c]), pkt[gs[c]]});
         n_vec++;
         if (wait_out !== ~oh) begin
            n_err++;
            $display("FAIL enable_wait[%0d]: got %b want %b", c, wait_out, ~oh);
         end
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         n_vec++;
         if (access_out !== 1'b1 || {grant_id, packet_out} !== exp_v) begin
            n_err++;
            $display("FAIL enable[%0d]: got access=%b id=%0d pkt=%h want id=%0d pkt=%h",
                     c, access_out, grant_id, packet_out, exp_v[W-1 -: 3], exp_v[PW-1:0]);
         end
      end
   endtask

   task automatic test_wrap();
      // ch2 alone moves ptr to 3; then {1,3} gives 3 then 1; then ch1 alone.
      logic [N-1:0] as [5] = '{4'b0100, 4'b1010, 4'b1010, 4'b0010, 4'b0010};
      int           gs [5] = '{2, 3, 1, 1, 1};
      logic [N-1:0] oh;
      logic [W-1:0] exp_v;
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, as[c], 4'b1111, 1'b0);
         oh = N'(1) << gs[c];
         exp_q.push_back({3'(gs[c]), pkt[gs[c]]});
         n_vec++;
         if (wait_out !== ~oh) begin
            n_err++;
            $display("FAIL wrap_wait[%0d]: got %b want %b", c, wait_out, ~oh);
         end
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         n_vec++;
         if (access_out !== 1'b1 || {grant_id, packet_out} !== exp_v) begin
            n_err++;
            $display("FAIL wrap[%0d]: got access=%b id=%0d pkt=%h want id=%0d pkt=%h",
                     c, access_out, grant_id, packet_out, exp_v[W-1 -: 3], exp_v[PW-1:0]);
         end
      end
   endtask

   task automatic test_lock();
`ifdef MRX_ARB_LOCK_EN
      int gs [7] = '{0, 0, 0, 1, 1, 1, 0};
`else
      int gs [7] = '{0, 1, 0, 1, 0, 1, 0};
`endif
      logic [W-1:0] exp_v;
      drive(1'b1, 4'b0011, 4'b1111, 1'b0);
      @(posedge clk); #1;
      for (int c = 0; c < 7; c++) begin
         drive(1'b0, 4'b0011, 4'b1111, 1'b0);
         exp_q.push_back({3'(gs[c]), pkt[gs[c]]});
         @(posedge clk); #1;
         exp_v = exp_q.pop_front();
         n_vec++;
         if (access_out !== 1'b1 || {grant_id, packet_out} !== exp_v) begin
            n_err++;
            $display("FAIL lock[%0d]: got access=%b id=%0d pkt=%h want id=%0d pkt=%h",
                     c, access_out, grant_id, packet_out, exp_v[W-1 -: 3], exp_v[PW-1:0]);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      reset = 1'b1; access_in = '0; en = '0; wait_in = 1'b0;
      new_pkts();
      test_reset();
      test_rotation();
      test_stall();
      test_enable();
      test_wrap();
      test_lock();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
